// File: rtl/nand_tt_sweeper.sv
// nand_tt_sweeper
//
// Clocked stimulus-and-check stage for a 2-input NAND gate. It walks the gate
// inputs through 00, 01, 10 and 11. Each pattern is held for SETTLE_CYCLES
// cycles, and then the gate output is compared against the expected NAND value.
// At the end of the sweep it reports a pass flag, a mismatch count and a
// per-pattern failure mask.
//
// Parameters:
//   SETTLE_CYCLES - cycles each pattern is held before sampling (1..15)
// Ports:
//   clk       - clock; all state changes on the rising edge
//   reset     - synchronous, active-high reset
//   start     - level request to begin a sweep; honoured only when idle
//   dut_s     - output of the gate under test
//   x, y      - registered gate inputs (pattern bit 1, pattern bit 0)
//   busy      - high while a sweep is in progress
//   done      - one-cycle pulse when a sweep completes
//   pass      - last completed sweep had no mismatches; held until next start
//   err_count - number of mismatching patterns (0..4)
//   fail_mask - bit i set when pattern i mismatched
module nand_tt_sweeper #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       dut_s,
   output logic       x,
   output logic       y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] fail_mask
);

   localparam logic [3:0] CntLast = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StWait, StSample, StFinish} state_e;

   state_e     state;
   logic [1:0] idx;
   logic [3:0] cnt;
   logic       mismatch;
   logic [2:0] err_next;
   logic [1:0] idx_next;

   always_comb begin
      mismatch = (dut_s != ~(x & y));
      err_next = err_count + {2'b00, mismatch};
      idx_next = idx + 2'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= StIdle;
         x         <= 1'b0;
         y         <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= 3'd0;
         fail_mask <= 4'b0000;
         idx       <= 2'd0;
         cnt       <= 4'd0;
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               x    <= 1'b0;
               y    <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  idx       <= 2'd0;
                  cnt       <= 4'd0;
                  err_count <= 3'd0;
                  fail_mask <= 4'b0000;
                  pass      <= 1'b0;
                  busy      <= 1'b1;
                  state     <= StWait;
               end
            end
            StWait: begin
               if (cnt == CntLast) begin
                  state <= StSample;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            StSample: begin
               if (mismatch) begin
                  err_count      <= err_next;
                  fail_mask[idx] <= 1'b1;
               end
               if (idx == 2'd3) begin
                  // Entering FINISH: busy drops on the same edge done rises,
                  // and pass must see the count including this last sample.
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == 3'd0);
                  x     <= 1'b0;
                  y     <= 1'b0;
                  state <= StFinish;
               end else begin
                  idx    <= idx_next;
                  {x, y} <= idx_next;
                  cnt    <= 4'd0;
                  state  <= StWait;
               end
            end
            StFinish: begin
               x     <= 1'b0;
               y     <= 1'b0;
               busy  <= 1'b0;
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_nand_tt_sweeper.sv
// Self-checking bench for nand_tt_sweeper. Instance a uses SETTLE_CYCLES = 2 and
// instance b uses SETTLE_CYCLES = 1. Each instance has a behavioural gate whose
// behaviour is selected by a mode value: 0 = NAND, 1 = stuck-at-0,
// 2 = stuck-at-1, 3 = AND.
module tb_nand_tt_sweeper;

   logic clk;
   logic reset;
   logic start_a, start_b;
   int   mode_a, mode_b;
   logic sel;

   logic       x_a, y_a, busy_a, done_a, pass_a, dut_s_a;
   logic [2:0] err_a;
   logic [3:0] mask_a;
   logic       x_b, y_b, busy_b, done_b, pass_b, dut_s_b;
   logic [2:0] err_b;
   logic [3:0] mask_b;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic gate(input int m, input logic a, input logic b);
      case (m)
         0:       return ~(a & b);
         1:       return 1'b0;
         2:       return 1'b1;
         default: return a & b;
      endcase
   endfunction

   assign dut_s_a = gate(mode_a, x_a, y_a);
   assign dut_s_b = gate(mode_b, x_b, y_b);

   nand_tt_sweeper #(.SETTLE_CYCLES(2)) u_dut_a (
      .clk(clk), .reset(reset), .start(start_a), .dut_s(dut_s_a),
      .x(x_a), .y(y_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .err_count(err_a), .fail_mask(mask_a)
   );

   nand_tt_sweeper #(.SETTLE_CYCLES(1)) u_dut_b (
      .clk(clk), .reset(reset), .start(start_b), .dut_s(dut_s_b),
      .x(x_b), .y(y_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .err_count(err_b), .fail_mask(mask_b)
   );

   logic [1:0] cur_xy;
   logic       cur_busy, cur_done, cur_pass;
   logic [2:0] cur_err;
   logic [3:0] cur_mask;
   assign cur_xy   = sel ? {x_b, y_b} : {x_a, y_a};
   assign cur_busy = sel ? busy_b : busy_a;
   assign cur_done = sel ? done_b : done_a;
   assign cur_pass = sel ? pass_b : pass_a;
   assign cur_err  = sel ? err_b  : err_a;
   assign cur_mask = sel ? mask_b : mask_a;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel) start_b = v;
      else     start_a = v;
   endtask

   // Pulses start, then follows the sweep edge by edge. k counts edges after
   // the edge that accepted start. With poke set, start is raised again so that
   // it is sampled on edges 3 and 7.
   task automatic run_sweep(input string tag, input logic poke, input int hold);
      int         per;
      int         exp_done;
      int         done_k;
      int         busy_n;
      logic [1:0] seq [0:40];
      per      = hold + 1;
      exp_done = 4 * per;
      done_k   = -1;
      busy_n   = 0;
      for (int i = 0; i <= 40; i++) seq[i] = 2'bxx;
      set_start(1'b1);
      tick();
      set_start(1'b0);
      for (int k = 0; k <= 40; k++) begin
         seq[k] = cur_xy;
         if (cur_busy) busy_n++;
         if (cur_done) begin
            done_k = k;
            break;
         end
         set_start(poke && (k == 2 || k == 6));
         tick();
      end
      set_start(1'b0);
      check({tag, "_done_edge"}, done_k, exp_done);
      check({tag, "_busy_cycles"}, busy_n, exp_done);
      for (int p = 0; p < 4; p++) begin
         check($sformatf("%s_pat%0d_first", tag, p), seq[p * per], p);
         check($sformatf("%s_pat%0d_last", tag, p), seq[p * per + hold], p);
      end
      check({tag, "_xy_at_done"}, seq[exp_done], 0);
   endtask

   // Called in the done cycle. Checks the results, then checks that done is a
   // single-cycle pulse and that the results are still held while idle.
   task automatic check_results(input string tag, input logic p, input logic [2:0] e,
                                input logic [3:0] m);
      check({tag, "_pass"}, cur_pass, p);
      check({tag, "_err"}, cur_err, e);
      check({tag, "_mask"}, cur_mask, m);
      tick();
      check({tag, "_done_pulse"}, {cur_done, cur_busy}, 2'b00);
      repeat (3) tick();
      check({tag, "_held"}, {cur_pass, cur_err, cur_mask}, {p, e, m});
   endtask

   initial begin
      reset   = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      mode_a  = 0;
      mode_b  = 0;
      sel     = 1'b0;
      repeat (3) tick();
      check("rst_a", {x_a, y_a, busy_a, done_a, pass_a, err_a, mask_a}, 0);
      check("rst_b", {x_b, y_b, busy_b, done_b, pass_b, err_b, mask_b}, 0);
      reset = 1'b0;
      tick();

      mode_a = 0; run_sweep("nand", 1'b0, 2); check_results("nand", 1'b1, 3'd0, 4'b0000);
      mode_a = 1; run_sweep("st0", 1'b0, 2);  check_results("st0", 1'b0, 3'd3, 4'b0111);
      mode_a = 2; run_sweep("st1", 1'b0, 2);  check_results("st1", 1'b0, 3'd1, 4'b1000);
      mode_a = 3; run_sweep("and", 1'b0, 2);  check_results("and", 1'b0, 3'd4, 4'b1111);
      mode_a = 0; run_sweep("poke", 1'b1, 2); check_results("poke", 1'b1, 3'd0, 4'b0000);

      // Reset mid-sweep with a stuck-at-0 gate: pattern 00 fails at edge 3.
      mode_a = 1;
      set_start(1'b1);
      tick();
      set_start(1'b0);
      repeat (4) tick();
      check("mid_err_before_rst", {busy_a, err_a, mask_a}, {1'b1, 3'd1, 4'b0001});
      reset = 1'b1;
      tick();
      check("mid_rst_outs", {x_a, y_a, busy_a, done_a, pass_a, err_a, mask_a}, 0);
      reset = 1'b0;
      tick();
      run_sweep("after_rst", 1'b0, 2);
      check_results("after_rst", 1'b0, 3'd3, 4'b0111);

      // Reset and start together: reset wins.
      reset   = 1'b1;
      start_a = 1'b1;
      tick();
      reset   = 1'b0;
      start_a = 1'b0;
      check("rst_start_same", busy_a, 1'b0);
      tick();
      check("rst_start_idle", busy_a, 1'b0);

      // Start held high: a new sweep begins on the edge after FINISH -> IDLE.
      mode_a = 0;
      start_a = 1'b1;
      begin
         int guard;
         guard = 0;
         tick();
         while (!done_a && guard < 40) begin
            tick();
            guard++;
         end
         check("held_done_seen", done_a, 1'b1);
         tick();
         check("held_idle_gap", busy_a, 1'b0);
         tick();
         check("held_restart", {busy_a, x_a, y_a}, 3'b100);
      end
      start_a = 1'b0;
      reset   = 1'b1;
      tick();
      reset   = 1'b0;
      tick();

      sel = 1'b1;
      mode_b = 0; run_sweep("s1", 1'b0, 1); check_results("s1", 1'b1, 3'd0, 4'b0000);
      mode_b = 1; run_sweep("s1_st0", 1'b0, 1); check_results("s1_st0", 1'b0, 3'd3, 4'b0111);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

endmodule
